// File: rtl/axi_mram_slave.sv
// AXI INCR burst slave driving a single-port MRAM wrapper; reads and writes share one port.
// Optional AXI_SLV_RANGE_CHECK_EN: out-of-range beats get SLVERR, no access, zero read data.
module axi_mram_slave #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MEM_AW         = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   awid,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATA_WIDTH-1:0] wdata,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [AXI_ID_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_ISSUE,
        RD_DATA
    } state_t;

    state_t state, state_nxt;

    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [24:0]               base_q;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic                      err_q;
    logic                      last_rd_q;
    logic                      rd_first_q;
    logic [AXI_DATA_WIDTH-1:0] rd_hold_q;

    logic        grant_wr;
    logic        grant_rd;
    logic        oor;
    logic        beat_last;
    logic [25:0] idx;

    // Full word index of the current beat; the extra top bit catches increment carry.
    assign idx       = {1'b0, base_q} + {18'd0, cnt_q};
    assign beat_last = (cnt_q == len_q);

`ifdef AXI_SLV_RANGE_CHECK_EN
    assign oor = |idx[25:MEM_AW];
`else
    assign oor = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{awaddr[AXI_ADDR_WIDTH-1:28], awaddr[2:0],
                         araddr[AXI_ADDR_WIDTH-1:28], araddr[2:0],
                         idx[25:MEM_AW]};

    assign grant_wr = awvalid & (~arvalid | last_rd_q);
    assign grant_rd = arvalid & ~grant_wr;
    assign awready  = (state == IDLE) & grant_wr;
    assign arready  = (state == IDLE) & grant_rd;

    assign mem_addr = idx[MEM_AW-1:0];
    assign bid      = id_q;
    assign rid      = id_q;
    // First RD_DATA cycle passes the macro output through; later cycles replay the captured copy.
    assign rdata    = rd_first_q ? (oor ? '0 : mem_rdata) : rd_hold_q;

    always_comb begin
        state_nxt = state;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        rvalid    = 1'b0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_DATA;
                else if (grant_rd) state_nxt = RD_ISSUE;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_req   = ~oor;
                    mem_we    = 1'b1;
                    mem_wdata = wdata;
                    if (beat_last) state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bresp  = err_q ? SLVERR : 2'b00;
                if (bready) state_nxt = IDLE;
            end
            RD_ISSUE: begin
                mem_req   = ~oor;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = beat_last;
                rresp  = oor ? SLVERR : 2'b00;
                if (rready) state_nxt = beat_last ? IDLE : RD_ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            id_q       <= '0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            last_rd_q  <= 1'b1;
            rd_first_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state      <= state_nxt;
            rd_first_q <= (state == RD_ISSUE);
            if (rd_first_q) rd_hold_q <= rdata;
            if (awready) begin
                id_q      <= awid;
                base_q    <= awaddr[27:3];
                len_q     <= awlen;
                cnt_q     <= '0;
                err_q     <= 1'b0;
                last_rd_q <= 1'b0;
            end
            if (arready) begin
                id_q      <= arid;
                base_q    <= araddr[27:3];
                len_q     <= arlen;
                cnt_q     <= '0;
                last_rd_q <= 1'b1;
            end
            if (state == WR_DATA && wvalid) begin
                if ((wlast != beat_last) || oor) err_q <= 1'b1;
                if (!beat_last) cnt_q <= cnt_q + 8'd1;
            end
            if (state == RD_DATA && rready && !beat_last)
                cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_mram_slave.sv
// Scoreboard bench for axi_mram_slave with a behavioural one-cycle-latency memory.
module tb_axi_mram_slave;

    localparam int IW  = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int MAW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0]  awid, arid, bid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic           awvalid, awready, arvalid, arready;
    logic [DW-1:0]  wdata, rdata, mem_wdata, mem_rdata;
    logic           wlast, wvalid, wready;
    logic [1:0]     bresp, rresp;
    logic           bvalid, bready, rlast, rvalid, rready;
    logic           mem_req, mem_we;
    logic [MAW-1:0] mem_addr;

    axi_mram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem [0:(1<<MAW)-1];
    initial mem_rdata = '0;
    always @(posedge clk)
        if (mem_req) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [75:0] q_w[$];
    logic [5:0]  q_b[$];
    logic [70:0] q_r[$];

    task automatic push_w(input logic [11:0] a, input logic [63:0] d);
        q_w.push_back({a, d});
    endtask
    task automatic push_b(input logic [3:0] id, input logic [1:0] r);
        q_b.push_back({id, r});
    endtask
    task automatic push_r(input logic [3:0] id, input logic [1:0] r,
                          input logic l, input logic [63:0] d);
        q_r.push_back({id, r, l, d});
    endtask

    logic        hold_v = 1'b0;
    logic [70:0] hold_r;

    always @(negedge clk) if (rst_n) begin
        if (mem_req) begin
            chk("ovl", {bvalid, rvalid}, 0);
            if (mem_we) begin
                if (q_w.size() == 0) chk("w_unexp", 1, 0);
                else chk("wbeat", {mem_addr, mem_wdata}, q_w.pop_front());
            end
        end
        if (bvalid && bready) begin
            if (q_b.size() == 0) chk("b_unexp", 1, 0);
            else chk("bresp", {bid, bresp}, q_b.pop_front());
        end
        if (hold_v) chk("rstable", {rvalid, rid, rresp, rlast, rdata}, {1'b1, hold_r});
        hold_v <= rvalid && !rready;
        hold_r <= {rid, rresp, rlast, rdata};
        if (rvalid && rready) begin
            if (q_r.size() == 0) chk("r_unexp", 1, 0);
            else chk("rbeat", {rid, rresp, rlast, rdata}, q_r.pop_front());
        end
    end

    task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        int t = 0;
        awid = id; awaddr = a; awlen = len; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 50) begin t++; @(negedge clk); end
        if (!awready) chk("aw_tmo", 0, 1);
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        int t = 0;
        arid = id; araddr = a; arlen = len; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 50) begin t++; @(negedge clk); end
        if (!arready) chk("ar_tmo", 0, 1);
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input logic [63:0] d0, input int last_at);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            wdata = d0 + 64'(i); wlast = (i == last_at); wvalid = 1'b1;
            @(negedge clk);
            while (!wready && t < 50) begin t++; @(negedge clk); end
            if (!wready) chk("w_tmo", 0, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b;
        int t = 0;
        bready = 1'b1;
        @(negedge clk);
        while (!bvalid && t < 50) begin t++; @(negedge clk); end
        if (!bvalid) chk("b_tmo", 0, 1);
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic get_r(input int n, input bit tog);
        int got = 0;
        int t = 0;
        while (got < n && t < 200) begin
            rready = !tog || (t % 2 == 1);
            @(negedge clk);
            if (rvalid && rready) got++;
            @(posedge clk); #1;
            t++;
        end
        if (got < n) chk("r_tmo", got, n);
        rready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {awready, wready, arready, bvalid, rvalid, rlast, mem_req, mem_we,
                  bid, bresp, rid, rresp, mem_addr}, 0);
        chk({tag, "_d"}, {rdata, 16'h0}, 0);
        chk({tag, "_wd"}, mem_wdata, 0);
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_idle("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) push_w(12'h20 + 12'(i), 64'hA0 + 64'(i));
        push_b(4'h9, 2'b00);
        do_aw(4'h9, 32'h0000_0100, 8'd3);
        chk("wr_rdy", wready, 1);
        send_w(4, 64'hA0, 3);
        chk("b_lat", bvalid, 1);
        get_b();

        for (int i = 0; i < 4; i++) push_r(4'h2, 2'b00, i == 3, 64'hA0 + 64'(i));
        do_ar(4'h2, 32'h0000_0100, 8'd3);
        chk("rd_iss", {mem_req, mem_we, rvalid}, 3'b100);
        @(posedge clk); #1 chk("rd_lat", rvalid, 1);
        get_r(4, 1'b1);

        for (int k = 0; k < 2; k++) begin
            logic [11:0] wa;
            logic [63:0] d;
            wa = 12'h40 + 12'(2 * k);
            d  = 64'hB0 + 64'(2 * k);
            push_w(wa, d); push_w(wa + 12'd1, d + 64'd1);
            push_b(4'h3, 2'b00);
            push_r(4'h4, 2'b00, 1'b0, d); push_r(4'h4, 2'b00, 1'b1, d + 64'd1);
            awid = 4'h3; awaddr = {17'd0, wa, 3'd0}; awlen = 8'd1;
            arid = 4'h4; araddr = {17'd0, wa, 3'd0}; arlen = 8'd1;
            awvalid = 1'b1; arvalid = 1'b1;
            #1 chk("arb", {awready, arready}, 2'b10);
            @(posedge clk); #1 awvalid = 1'b0;
            send_w(2, d, 1);
            get_b();
            do_ar(4'h4, {17'd0, wa, 3'd0}, 8'd1);
            get_r(2, 1'b0);
        end

        push_w(12'h50, 64'hC0); push_w(12'h51, 64'hC1);
        push_b(4'h5, 2'b10);
        do_aw(4'h5, 32'h0000_0280, 8'd1);
        send_w(2, 64'hC0, 0);
        get_b();

        push_w(12'h000, 64'hE0); push_b(4'h6, 2'b00);
        do_aw(4'h6, 32'h0000_0000, 8'd0);
        send_w(1, 64'hE0, 0);
        get_b();
        push_w(12'hFFF, 64'hD0); push_b(4'h6, 2'b00);
        do_aw(4'h6, 32'h0000_7FF8, 8'd0);
        send_w(1, 64'hD0, 0);
        get_b();

        push_r(4'h7, 2'b00, 1'b0, 64'hD0);
`ifdef AXI_SLV_RANGE_CHECK_EN
        push_r(4'h7, 2'b10, 1'b1, 64'h0);
`else
        push_r(4'h7, 2'b00, 1'b1, 64'hE0);
`endif
        do_ar(4'h7, 32'h0000_7FF8, 8'd1);
        get_r(2, 1'b0);

        push_r(4'hA, 2'b00, 1'b1, 64'hA0);
        do_ar(4'hA, 32'h3000_0100, 8'd0);
        get_r(1, 1'b1);

        push_w(12'hFFF, 64'hD5);
`ifdef AXI_SLV_RANGE_CHECK_EN
        push_b(4'h8, 2'b10);
`else
        push_w(12'h000, 64'hD6);
        push_b(4'h8, 2'b00);
`endif
        do_aw(4'h8, 32'h0000_7FF8, 8'd1);
        send_w(2, 64'hD5, 1);
        get_b();

        push_w(12'h60, 64'hF0); push_w(12'h61, 64'hF1);
        do_aw(4'h1, 32'h0000_0300, 8'd3);
        send_w(2, 64'hF0, 9);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk_idle("rst_mid");
        repeat (3) begin
            @(negedge clk); chk("no_b", bvalid, 0);
        end
        @(posedge clk); #1;
        push_w(12'h60, 64'hF8); push_b(4'h1, 2'b00);
        do_aw(4'h1, 32'h0000_0300, 8'd0);
        send_w(1, 64'hF8, 0);
        get_b();
        push_r(4'h1, 2'b00, 1'b0, 64'hF8); push_r(4'h1, 2'b00, 1'b1, 64'hF1);
        do_ar(4'h1, 32'h0000_0300, 8'd1);
        get_r(2, 1'b1);

        repeat (3) @(posedge clk);
        chk("q_w", q_w.size(), 0);
        chk("q_b", q_b.size(), 0);
        chk("q_r", q_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
